// File: rtl/seq_det_pkg.sv
// -----------------------------------------------------------------------------
// seq_det_pkg
// Shared constants and elaboration-time helpers for the parametrised Mealy
// sequence detector.
//
// Contents:
//   MAX_PAT_W  - widest pattern the detector supports (16 bits)
//   prefix_len - KMP prefix value: the length of the longest proper prefix of
//                the first k pattern bits that is also a suffix of those bits
//   fallback   - the state reached after a mismatch in state k on a given bit
//
// Pattern bit numbering in these helpers: position 0 is the first bit
// received, which is pattern[width-1].
// -----------------------------------------------------------------------------
package seq_det_pkg;

   localparam int MAX_PAT_W = 16;

   // Longest proper prefix of the first k pattern bits that is also a suffix
   // of those same k bits. The search runs from the longest candidate down, so
   // the first hit is the answer.
   function automatic int prefix_len(input logic [MAX_PAT_W-1:0] pattern,
                                     input int width,
                                     input int k);
      int   res;
      logic ok;
      res = 0;
      for (int len = MAX_PAT_W - 1; len >= 1; len--) begin
         if (res == 0 && len < k) begin
            ok = 1'b1;
            for (int i = 0; i < MAX_PAT_W; i++) begin
               if (i < len) begin
                  if (pattern[width-1-i] != pattern[width-1-(k-len+i)])
                     ok = 1'b0;
               end
            end
            if (ok) res = len;
         end
      end
      return res;
   endfunction

   // The received history in state k is the first k pattern bits followed by
   // b. The result is the longest j <= k for which the last j received bits
   // equal the first j pattern bits, so no partial match is lost.
   function automatic int fallback(input logic [MAX_PAT_W-1:0] pattern,
                                   input int   width,
                                   input int   k,
                                   input logic b);
      int   res;
      int   pos;
      logic ok;
      logic s_bit;
      res = 0;
      for (int j = MAX_PAT_W; j >= 1; j--) begin
         if (res == 0 && j <= k) begin
            ok = 1'b1;
            for (int i = 0; i < MAX_PAT_W; i++) begin
               if (i < j) begin
                  pos = k - j + 1 + i;
                  if (pos == k) s_bit = b;
                  else          s_bit = pattern[width-1-pos];
                  if (s_bit != pattern[width-1-i]) ok = 1'b0;
               end
            end
            if (ok) res = j;
         end
      end
      return res;
   endfunction

endpackage

// File: rtl/seq_match_counter.sv
// -----------------------------------------------------------------------------
// seq_match_counter
// Saturating match counter with synchronous clear. A clear that coincides
// with a match leaves the count at 1, so that match is not lost.
//
// Ports:
//   clk      in   clock, rising edge
//   reset_n  in   synchronous active-low reset
//   inc      in   count one match on this edge
//   clr      in   synchronous clear
//   cnt      out  CNT_W-bit match count, sticks at all ones
//   sat      out  high while cnt is all ones
// -----------------------------------------------------------------------------
module seq_match_counter #(
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             inc,
   input  logic             clr,
   output logic [CNT_W-1:0] cnt,
   output logic             sat
);

   assign sat = &cnt;

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         cnt <= '0;
      end else if (clr) begin
         cnt <= inc ? CNT_W'(1) : '0;
      end else if (inc && !sat) begin
         cnt <= cnt + CNT_W'(1);
      end
   end

endmodule

// File: rtl/seq_detect_mealy_param.sv
// -----------------------------------------------------------------------------
// seq_detect_mealy_param
// Mealy detector for an arbitrary PAT_W-bit serial pattern, with overlapping
// or non-overlapping detection. Mismatches fall back through a KMP-derived
// table built at elaboration time, so partial matches survive a wrong bit.
//
// Build option:
//   SEQ_DET_COUNT_EN  defined   -> saturating match counter, cnt_clr, cnt_sat
//                     undefined -> match_cnt and cnt_sat tied to 0,
//                                  cnt_clr ignored
//
// Ports:
//   clk        in   clock, rising edge
//   reset_n    in   synchronous active-low reset
//   in_valid   in   in_bit is consumed only when high
//   in_bit     in   serial data, first bit of the pattern is PATTERN[PAT_W-1]
//   cnt_clr    in   synchronous clear of match_cnt
//   pat_match  out  combinational match pulse, same cycle as the final bit
//   match_cnt  out  CNT_W-bit saturating match count
//   cnt_sat    out  high while match_cnt is all ones
// -----------------------------------------------------------------------------
module seq_detect_mealy_param
   import seq_det_pkg::*;
#(
   parameter int               PAT_W   = 3,
   parameter logic [PAT_W-1:0] PATTERN = 3'b101,
   parameter bit               OVERLAP = 1'b1,
   parameter int               CNT_W   = 8
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             in_valid,
   input  logic             in_bit,
   input  logic             cnt_clr,
   output logic             pat_match,
   output logic [CNT_W-1:0] match_cnt,
   output logic             cnt_sat
);

   // State = number of pattern bits matched so far (0..PAT_W-1).
   localparam int SW = (PAT_W > 2) ? $clog2(PAT_W) : 1;
   localparam int NS = 1 << SW;
   localparam logic [MAX_PAT_W-1:0] PAT_EXT = MAX_PAT_W'(PATTERN);
   localparam int PI_FULL = prefix_len(PAT_EXT, PAT_W, PAT_W);
   localparam logic [SW-1:0] LAST = SW'(PAT_W - 1);

   if (PAT_W < 2 || PAT_W > MAX_PAT_W) begin : g_bad_width
      $error("seq_detect_mealy_param: PAT_W must lie in 2..16");
   end

   logic [SW-1:0]          state;
   logic [SW-1:0]          state_nxt;
   logic [NS-1:0]          exp_tab;
   logic [NS-1:0][SW-1:0]  fb0_tab;
   logic [NS-1:0][SW-1:0]  fb1_tab;
   logic                   exp_bit;

   // Per-state expected bit and mismatch targets; entries beyond PAT_W-1
   // are unreachable and padded so the tables index cleanly by state.
   for (genvar k = 0; k < NS; k++) begin : g_tab
      if (k < PAT_W) begin : g_used
         localparam int F0 = fallback(PAT_EXT, PAT_W, k, 1'b0);
         localparam int F1 = fallback(PAT_EXT, PAT_W, k, 1'b1);
         assign exp_tab[k] = PATTERN[PAT_W-1-k];
         assign fb0_tab[k] = SW'(F0);
         assign fb1_tab[k] = SW'(F1);
      end else begin : g_pad
         assign exp_tab[k] = 1'b0;
         assign fb0_tab[k] = '0;
         assign fb1_tab[k] = '0;
      end
   end

   assign exp_bit = exp_tab[state];

   // State register
   always_ff @(posedge clk) begin
      if (!reset_n) state <= '0;
      else          state <= state_nxt;
   end

   // Next-state logic
   always_comb begin
      state_nxt = state;
      if (in_valid) begin
         if (in_bit == exp_bit) begin
            if (state == LAST) begin
               // Overlapping mode keeps the pattern's border as a fresh
               // partial match; non-overlapping mode starts over.
               state_nxt = OVERLAP ? SW'(PI_FULL) : '0;
            end else begin
               state_nxt = state + SW'(1);
            end
         end else begin
            state_nxt = in_bit ? fb1_tab[state] : fb0_tab[state];
         end
      end
   end

   // Output logic: gated by reset so no pulse escapes while state is forced
   always_comb begin
      pat_match = reset_n & in_valid & (state == LAST) & (in_bit == PATTERN[0]);
   end

`ifdef SEQ_DET_COUNT_EN
   seq_match_counter #(
      .CNT_W (CNT_W)
   ) u_match_counter (
      .clk     (clk),
      .reset_n (reset_n),
      .inc     (pat_match),
      .clr     (cnt_clr),
      .cnt     (match_cnt),
      .sat     (cnt_sat)
   );
`else
   logic unused_cnt_clr;
   assign unused_cnt_clr = cnt_clr;
   assign match_cnt      = '0;
   assign cnt_sat        = 1'b0;
`endif

endmodule

// File: tb/tb_seq_detect_mealy_param.sv
module tb_seq_detect_mealy_param;

`ifdef SEQ_DET_COUNT_EN
   localparam bit CNT_EN = 1'b1;
`else
   localparam bit CNT_EN = 1'b0;
`endif

   logic clk;
   logic reset_n;
   logic in_valid;
   logic in_bit;
   logic cnt_clr;

   logic       pm_a, pm_b, pm_c, pm_d;
   logic [1:0] mc_a;
   logic [7:0] mc_b, mc_c;
   logic [2:0] mc_d;
   logic       cs_a, cs_b, cs_c, cs_d;

   logic       pm [4];
   logic [7:0] mc [4];
   logic       cs [4];

   assign pm[0] = pm_a;  assign mc[0] = {6'b0, mc_a}; assign cs[0] = cs_a;
   assign pm[1] = pm_b;  assign mc[1] = mc_b;         assign cs[1] = cs_b;
   assign pm[2] = pm_c;  assign mc[2] = mc_c;         assign cs[2] = cs_c;
   assign pm[3] = pm_d;  assign mc[3] = {5'b0, mc_d}; assign cs[3] = cs_d;

   // A: 101 overlapping, 2-bit counter
   seq_detect_mealy_param #(.PAT_W(3), .PATTERN(3'b101), .OVERLAP(1'b1), .CNT_W(2)) dut_a (
      .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_bit(in_bit), .cnt_clr(cnt_clr),
      .pat_match(pm_a), .match_cnt(mc_a), .cnt_sat(cs_a));
   // B: 101 non-overlapping
   seq_detect_mealy_param #(.PAT_W(3), .PATTERN(3'b101), .OVERLAP(1'b0), .CNT_W(8)) dut_b (
      .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_bit(in_bit), .cnt_clr(cnt_clr),
      .pat_match(pm_b), .match_cnt(mc_b), .cnt_sat(cs_b));
   // C: 1101 overlapping
   seq_detect_mealy_param #(.PAT_W(4), .PATTERN(4'b1101), .OVERLAP(1'b1), .CNT_W(8)) dut_c (
      .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_bit(in_bit), .cnt_clr(cnt_clr),
      .pat_match(pm_c), .match_cnt(mc_c), .cnt_sat(cs_c));
   // D: 110110 non-overlapping, 3-bit counter
   seq_detect_mealy_param #(.PAT_W(6), .PATTERN(6'b110110), .OVERLAP(1'b0), .CNT_W(3)) dut_d (
      .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_bit(in_bit), .cnt_clr(cnt_clr),
      .pat_match(pm_d), .match_cnt(mc_d), .cnt_sat(cs_d));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference model: a match is the last PAT_W received bits equalling the
   // pattern, counted only over bits received since reset (and, without
   // overlap, since the previous match).
   int          pw   [4] = '{3, 3, 4, 6};
   logic [31:0] pv   [4] = '{32'd5, 32'd5, 32'd13, 32'd54};
   bit          ov   [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
   int          cmax [4] = '{3, 255, 255, 7};
   logic [31:0] hist [4];
   int          since[4];
   int          mcnt [4];

   int total = 0;
   int bad   = 0;
   int nstep = 0;

   function automatic logic model_match(input int d, input logic v, input logic b, input logic rn);
      logic [31:0] h;
      logic [31:0] mask;
      h    = {hist[d][30:0], b};
      mask = (32'd1 << pw[d]) - 32'd1;
      return rn && v && (since[d] + 1 >= pw[d]) && ((h & mask) == pv[d]);
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      total++;
      assert (obs === expv) else begin
         bad++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
      end
   endtask

   task automatic step(input logic v, input logic b, input logic clr, input logic rn);
      logic em [4];
      @(negedge clk);
      in_valid = v; in_bit = b; cnt_clr = clr; reset_n = rn;
      #1;
      for (int d = 0; d < 4; d++) begin
         em[d] = model_match(d, v, b, rn);
         check($sformatf("pat_match[%0d] step %0d", d, nstep), {31'b0, pm[d]}, {31'b0, em[d]});
         check($sformatf("match_cnt[%0d] step %0d", d, nstep), {24'b0, mc[d]}, mcnt[d]);
         check($sformatf("cnt_sat[%0d] step %0d", d, nstep), {31'b0, cs[d]},
               {31'b0, (mcnt[d] == cmax[d])});
      end
      @(posedge clk);
      for (int d = 0; d < 4; d++) begin
         if (!rn) begin
            hist[d] = '0; since[d] = 0; mcnt[d] = 0;
         end else begin
            if (CNT_EN) begin
               if (clr)                            mcnt[d] = em[d] ? 1 : 0;
               else if (em[d] && mcnt[d] < cmax[d]) mcnt[d]++;
            end
            if (v) begin
               hist[d] = {hist[d][30:0], b};
               if (em[d] && !ov[d])      since[d] = 0;
               else if (since[d] < 1000) since[d]++;
            end
         end
      end
      nstep++;
   endtask

   task automatic feed(input logic [31:0] bits, input int n);
      for (int i = n - 1; i >= 0; i--) step(1'b1, bits[i], 1'b0, 1'b1);
   endtask

   initial begin
      for (int d = 0; d < 4; d++) begin
         hist[d] = '0; since[d] = 0; mcnt[d] = 0;
      end
      reset_n = 1'b0; in_valid = 1'b0; in_bit = 1'b0; cnt_clr = 1'b0;
      repeat (2) @(posedge clk);

      // Reset state
      step(1'b1, 1'b1, 1'b0, 1'b0);

      // 1,0,1,0,1: overlapping sees 2 matches, non-overlapping sees 1
      feed(32'b10101, 5);
      #1;
      check("plan1 cnt A", {24'b0, mc[0]}, CNT_EN ? 2 : 0);
      check("plan1 cnt B", {24'b0, mc[1]}, CNT_EN ? 1 : 0);

      // 1101 after 1,1,1,0,1: fallback keeps "11"
      step(1'b0, 1'b0, 1'b0, 1'b0);
      feed(32'b11101, 5);
      #1;
      check("plan2 cnt C", {24'b0, mc[2]}, CNT_EN ? 1 : 0);

      // Gaps in in_valid keep the partial match
      step(1'b0, 1'b0, 1'b0, 1'b0);
      step(1'b1, 1'b1, 1'b0, 1'b1);
      repeat (3) step(1'b0, 1'b1, 1'b0, 1'b1);
      step(1'b1, 1'b0, 1'b0, 1'b1);
      step(1'b1, 1'b1, 1'b0, 1'b1);
      #1;
      check("plan3 cnt A", {24'b0, mc[0]}, CNT_EN ? 1 : 0);

      // Saturation of the 2-bit counter, then clear coinciding with a match
      step(1'b0, 1'b0, 1'b0, 1'b0);
      feed(32'b10101010101, 11);
      #1;
      check("plan4 sat cnt A", {24'b0, mc[0]}, CNT_EN ? 3 : 0);
      check("plan4 sat flag A", {31'b0, cs[0]}, {31'b0, CNT_EN});
      step(1'b1, 1'b0, 1'b0, 1'b1);
      step(1'b1, 1'b1, 1'b1, 1'b1);
      #1;
      check("plan4 clr+match A", {24'b0, mc[0]}, CNT_EN ? 1 : 0);

      // Reset mid-pattern discards the partial match
      step(1'b0, 1'b0, 1'b0, 1'b0);
      feed(32'b10, 2);
      step(1'b0, 1'b0, 1'b0, 1'b0);
      step(1'b1, 1'b1, 1'b0, 1'b1);
      #1;
      check("plan5 no match A", {24'b0, mc[0]}, 0);
      feed(32'b01, 2);
      #1;
      check("plan5 match A", {24'b0, mc[0]}, CNT_EN ? 1 : 0);

      // Randomised traffic with occasional clears and resets
      for (int i = 0; i < 1500; i++) begin
         step(($urandom % 4) != 0, $urandom % 2, ($urandom % 64) == 0,
              ($urandom % 200) != 0);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/seq_detect_mealy_param.md
# seq_detect_mealy_param

Parametrised Mealy sequence detector, the general successor of the fixed-pattern 101 detectors in the FSM block set. It recognises an arbitrary PAT_W-bit serial pattern, in overlapping or non-overlapping mode. Fallback on a mismatch uses a prefix (KMP) table, so no partial match is lost. A qualified input strobe and a saturating match counter are included. It sits between a serial bit source and any logic that needs a same-cycle match pulse.

## Interface
- PAT_W, 3: pattern length in bits, 2..16
- PATTERN, 3'b101: pattern value; the first-received bit is PATTERN[PAT_W-1]
- OVERLAP, 1: 1 = overlapping detection, 0 = non-overlapping
- CNT_W, 8: match counter width
- clk  input  1  clock; all state updates on the rising edge
- reset_n  input  1  synchronous, active-low reset
- in_valid  input  1  in_bit is sampled only when high
- in_bit  input  1  serial data bit
- cnt_clr  input  1  synchronous clear of the match counter
- pat_match  output  1  Mealy match pulse, combinational
- match_cnt  output  CNT_W  number of matches, saturating
- cnt_sat  output  1  high while match_cnt is all ones

## Operation
- State encoding: state = number of pattern bits currently matched, range 0..PAT_W-1. Width is clog2(PAT_W), minimum 1 bit.
- Expected bit in state k: PATTERN[PAT_W-1-k].
- Transitions, applied only when in_valid=1:
  - in_bit equals expected bit and k<PAT_W-1: next state is k+1.
  - in_bit equals expected bit and k=PAT_W-1 (full match):
    - OVERLAP=1: next state is pi(PAT_W), the longest proper prefix that is also a suffix of PATTERN.
    - OVERLAP=0: next state is 0.
  - Mismatch: next state is the largest j ≤ k such that the last j received bits equal the first j pattern bits. This comes from the precomputed table fb[k][in_bit].
- in_valid=0: state holds and pat_match=0.
- pat_match = in_valid & (state==PAT_W-1) & (in_bit==PATTERN[0]). It has no register; it is valid in the same cycle as the final bit.
- Counter behaviour:
  - match_cnt increments by 1 on each clock edge where pat_match=1.
  - It saturates at 2^CNT_W-1 and does not wrap.
- cnt_clr=1 with pat_match=1 in the same cycle: match_cnt becomes 1.
- cnt_clr=1 with no match: match_cnt becomes 0.
- cnt_sat is decoded combinationally from match_cnt.

## Timing
- Reset values: state=0, match_cnt=0, cnt_sat=0. pat_match=0 while reset_n=0, because the output is gated by reset.
- Reset asserted mid-pattern discards the partial match. The first in_valid bit after deassertion is treated as pattern bit 0.
- Match latency: 0 cycles for pat_match; match_cnt updates 1 cycle after the pulse.
- Back-to-back matches: with OVERLAP=1, matches can occur every PAT_W-pi(PAT_W) valid bits.
- Gaps in in_valid do not break a partial match.
- Transition tables are elaboration-time constants. There is no run-time pattern change.

## Configuration
- SEQ_DET_COUNT_EN defined: the counter, cnt_clr and cnt_sat are implemented as described above.
- SEQ_DET_COUNT_EN undefined:
  - Counter logic is removed.
  - match_cnt is tied to 0 and cnt_sat is tied to 0.
  - cnt_clr is ignored.
  - pat_match behaviour is unchanged.

## Structure
- Package seq_det_pkg holds:
  - function prefix_len(pattern, width, k), which computes the KMP prefix values;
  - function fallback(pattern, width, k, bit), which builds fb;
  - constant MAX_PAT_W=16.
- The top module holds the state register, transition logic and pat_match.
- Sub-module seq_match_counter (parameter CNT_W) holds the saturating counter and the clear logic. It is instantiated only under SEQ_DET_COUNT_EN.

## Test plan
- PATTERN=101, OVERLAP=1, valid stream 1,0,1,0,1 -> pat_match on bits 3 and 5; match_cnt=2.
- PATTERN=101, OVERLAP=0, same stream -> pat_match on bit 3 only; match_cnt=1.
- PAT_W=4, PATTERN=1101, stream 1,1,1,0,1 -> state sequence 1,2,2,3, then pat_match on bit 5. This checks that fallback keeps "11".
- PATTERN=101, stream 1,(in_valid=0 for 3 cycles),0,1 -> single pat_match on the final bit; no pulse during the gap.
- CNT_W=2, OVERLAP=1, stream 10101010101 (5 matches) -> match_cnt sticks at 3 and cnt_sat=1. Then cnt_clr together with a match -> match_cnt=1.
- Stream 1,0, then reset_n=0 for 1 cycle, then 1 -> no match. Then 0,1 -> match on the second 1.
